// File: rtl/string_detector_param.sv
// string_detector_param: detects RUN_LEN consecutive qualified samples equal to
// a selectable target bit. Supports level (overlapping) and restart
// (non-overlapping) modes, reports the live run length and keeps a saturating
// count of detections. All outputs are registered; out is a Moore decode of
// the state register.

module string_detector_param #(
    parameter int  RUN_LEN = 3,
    parameter int  CNT_W   = 8,
    localparam int RL_W    = $clog2(RUN_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             in,
    input  logic             target,
    input  logic             mode,
    output logic             out,
    output logic             hit,
    output logic [RL_W-1:0]  run_len,
    output logic [CNT_W-1:0] hit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HIT  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [RL_W-1:0]  RUN_LEN_V = RL_W'(RUN_LEN);
    localparam logic [RL_W-1:0]  RL_ONE    = RL_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [RL_W-1:0]  run_len_q, run_len_d;
    logic             hit_q, hit_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic             match;
    logic [RL_W-1:0]  run_len_inc;

    assign match       = (in == target);
    assign run_len_inc = run_len_q + RL_ONE;

    // Next-state, run length, hit pulse and counter; clr beats en, en=0 freezes
    // everything except the hit pulse, which is always dropped.
    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        hit_d     = 1'b0;
        hit_cnt_d = hit_cnt_q;

        if (clr) begin
            state_d   = S_IDLE;
            run_len_d = '0;
            hit_cnt_d = '0;
        end else if (en) begin
            if (!match) begin
                state_d   = S_IDLE;
                run_len_d = '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        run_len_d = RL_ONE;
                        state_d   = (RUN_LEN == 1) ? S_HIT : S_RUN;
                    end
                    S_RUN: begin
                        run_len_d = run_len_inc;
                        state_d   = (run_len_inc == RUN_LEN_V) ? S_HIT : S_RUN;
                    end
                    S_HIT: begin
                        if (mode) begin
                            run_len_d = RL_ONE;
                            state_d   = (RUN_LEN == 1) ? S_HIT : S_RUN;
                        end else begin
                            state_d   = S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        state_d = S_HOLD;
                    end
                    default: begin
                        state_d   = S_IDLE;
                        run_len_d = '0;
                    end
                endcase

                // Every qualified edge that lands in S_HIT is a new detection,
                // including S_HIT->S_HIT restarts when RUN_LEN is 1.
                if (state_d == S_HIT) begin
                    hit_d = 1'b1;
                    if (hit_cnt_q != CNT_MAX) begin
                        hit_cnt_d = hit_cnt_q + CNT_ONE;
                    end
                end
            end
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            run_len_q <= '0;
            hit_q     <= 1'b0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            run_len_q <= run_len_d;
            hit_q     <= hit_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign out     = (state_q == S_HIT) || (state_q == S_HOLD);
    assign hit     = hit_q;
    assign run_len = run_len_q;
    assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_string_detector_param.sv
// tb_string_detector_param: table-driven directed test of string_detector_param
// with RUN_LEN=3/CNT_W=8 plus a RUN_LEN=1/CNT_W=2 instance for saturation and
// back-to-back pulses, and hand-written clr / async reset sequences.

module tb_string_detector_param;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       in_bit;
    logic       target;
    logic       mode;

    logic       out3;
    logic       hit3;
    logic [1:0] run_len3;
    logic [7:0] hit_cnt3;

    logic       out1;
    logic       hit1;
    logic [0:0] run_len1;
    logic [1:0] hit_cnt1;

    int checks;
    int failures;

    typedef struct {
        logic       en;
        logic       clr;
        logic       in_bit;
        logic       target;
        logic       mode;
        logic       out;
        logic       hit;
        logic [1:0] rl;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs3[$];
    vec_t vecs1[$];

    string_detector_param #(.RUN_LEN(3), .CNT_W(8)) u_dut3 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .in      (in_bit),
        .target  (target),
        .mode    (mode),
        .out     (out3),
        .hit     (hit3),
        .run_len (run_len3),
        .hit_cnt (hit_cnt3)
    );

    string_detector_param #(.RUN_LEN(1), .CNT_W(2)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .in      (in_bit),
        .target  (target),
        .mode    (mode),
        .out     (out1),
        .hit     (hit1),
        .run_len (run_len1),
        .hit_cnt (hit_cnt1)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(logic e, logic c, logic i, logic t, logic m,
                                logic o, logic h, logic [1:0] rl, logic [7:0] cnt);
        vec_t v;
        v.en = e; v.clr = c; v.in_bit = i; v.target = t; v.mode = m;
        v.out = o; v.hit = h; v.rl = rl; v.cnt = cnt;
        return v;
    endfunction

    task automatic check_value(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check3(string tag, logic o, logic h, logic [1:0] rl, logic [7:0] cnt);
        check_value({tag, ".out"},     32'(out3),     32'(o));
        check_value({tag, ".hit"},     32'(hit3),     32'(h));
        check_value({tag, ".run_len"}, 32'(run_len3), 32'(rl));
        check_value({tag, ".hit_cnt"}, 32'(hit_cnt3), 32'(cnt));
    endtask

    task automatic check1(string tag, logic o, logic h, logic rl, logic [1:0] cnt);
        check_value({tag, ".out"},     32'(out1),     32'(o));
        check_value({tag, ".hit"},     32'(hit1),     32'(h));
        check_value({tag, ".run_len"}, 32'(run_len1), 32'(rl));
        check_value({tag, ".hit_cnt"}, 32'(hit_cnt1), 32'(cnt));
    endtask

    // Drive one sample, take one edge, leave time to settle before checking.
    task automatic apply_stimulus(logic e, logic c, logic i, logic t, logic m);
        en = e; clr = c; in_bit = i; target = t; mode = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0; en = 1'b0; clr = 1'b0; in_bit = 1'b0; target = 1'b1; mode = 1'b0;

        // RUN_LEN=3 table:              en clr in tg md | out hit rl cnt
        // level mode, 0,1,1,1,1,1,0
        vecs3.push_back(mk(1, 0, 0, 1, 0,  0, 0, 0, 0));
        vecs3.push_back(mk(1, 0, 1, 1, 0,  0, 0, 1, 0));
        vecs3.push_back(mk(1, 0, 1, 1, 0,  0, 0, 2, 0));
        vecs3.push_back(mk(1, 0, 1, 1, 0,  1, 1, 3, 1));
        vecs3.push_back(mk(1, 0, 1, 1, 0,  1, 0, 3, 1));
        vecs3.push_back(mk(1, 0, 1, 1, 0,  1, 0, 3, 1));
        vecs3.push_back(mk(1, 0, 0, 1, 0,  0, 0, 0, 1));
        // clear, then restart mode with six 1s
        vecs3.push_back(mk(1, 1, 1, 1, 1,  0, 0, 0, 0));
        vecs3.push_back(mk(1, 0, 1, 1, 1,  0, 0, 1, 0));
        vecs3.push_back(mk(1, 0, 1, 1, 1,  0, 0, 2, 0));
        vecs3.push_back(mk(1, 0, 1, 1, 1,  1, 1, 3, 1));
        vecs3.push_back(mk(1, 0, 1, 1, 1,  0, 0, 1, 1));
        vecs3.push_back(mk(1, 0, 1, 1, 1,  0, 0, 2, 1));
        vecs3.push_back(mk(1, 0, 1, 1, 1,  1, 1, 3, 2));
        // target=0 with a four-clock stall in the middle of the run
        vecs3.push_back(mk(1, 0, 1, 0, 1,  0, 0, 0, 2));
        vecs3.push_back(mk(1, 0, 0, 0, 1,  0, 0, 1, 2));
        vecs3.push_back(mk(1, 0, 0, 0, 1,  0, 0, 2, 2));
        vecs3.push_back(mk(0, 0, 1, 0, 1,  0, 0, 2, 2));
        vecs3.push_back(mk(0, 0, 1, 0, 1,  0, 0, 2, 2));
        vecs3.push_back(mk(0, 0, 0, 0, 1,  0, 0, 2, 2));
        vecs3.push_back(mk(0, 0, 1, 0, 1,  0, 0, 2, 2));
        vecs3.push_back(mk(1, 0, 0, 0, 1,  1, 1, 3, 3));
        // stall while in S_HIT: out holds, hit drops
        vecs3.push_back(mk(0, 0, 0, 0, 1,  1, 0, 3, 3));
        // switch to level mode mid-run: continue into S_HOLD without a pulse
        vecs3.push_back(mk(1, 0, 0, 0, 0,  1, 0, 3, 3));
        // target flips to 1 while in=1: run continues, no recount
        vecs3.push_back(mk(1, 0, 1, 1, 0,  1, 0, 3, 3));
        vecs3.push_back(mk(1, 0, 0, 1, 0,  0, 0, 0, 3));

        // RUN_LEN=1, CNT_W=2 table (run_len/hit_cnt in low bits)
        vecs1.push_back(mk(1, 1, 1, 1, 1,  0, 0, 0, 0));
        vecs1.push_back(mk(1, 0, 1, 1, 1,  1, 1, 1, 1));
        vecs1.push_back(mk(1, 0, 1, 1, 1,  1, 1, 1, 2));
        vecs1.push_back(mk(1, 0, 1, 1, 1,  1, 1, 1, 3));
        vecs1.push_back(mk(1, 0, 1, 1, 1,  1, 1, 1, 3));
        vecs1.push_back(mk(1, 0, 1, 1, 1,  1, 1, 1, 3));
        vecs1.push_back(mk(1, 0, 1, 1, 1,  1, 1, 1, 3));
        vecs1.push_back(mk(0, 0, 1, 1, 1,  1, 0, 1, 3));
        vecs1.push_back(mk(1, 0, 0, 1, 1,  0, 0, 0, 3));

        // Reset state, visible with no clock edge taken.
        #1;
        check3("reset3", 0, 0, 0, 0);
        check1("reset1", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs3.size(); i++) begin
            apply_stimulus(vecs3[i].en, vecs3[i].clr, vecs3[i].in_bit,
                           vecs3[i].target, vecs3[i].mode);
            check3($sformatf("v3[%0d]", i), vecs3[i].out, vecs3[i].hit,
                   vecs3[i].rl, vecs3[i].cnt);
        end

        // clr with a matching qualified sample after two matches.
        apply_stimulus(1, 0, 1, 1, 0);
        apply_stimulus(1, 0, 1, 1, 0);
        check3("pre_clr", 0, 0, 2, 3);
        apply_stimulus(1, 1, 1, 1, 0);
        check3("clr", 0, 0, 0, 0);

        // Two matches, then an asynchronous reset pulse between edges.
        apply_stimulus(1, 0, 1, 1, 0);
        apply_stimulus(1, 0, 1, 1, 0);
        check3("pre_rst", 0, 0, 2, 0);
        #2 rst = 1'b0;
        #1;
        check3("async_rst", 0, 0, 0, 0);
        #1 rst = 1'b1;

        // A full run of three is needed again after reset.
        apply_stimulus(1, 0, 1, 1, 0);
        check3("post_rst1", 0, 0, 1, 0);
        apply_stimulus(1, 0, 1, 1, 0);
        check3("post_rst2", 0, 0, 2, 0);
        apply_stimulus(1, 0, 1, 1, 0);
        check3("post_rst3", 1, 1, 3, 1);

        for (int i = 0; i < vecs1.size(); i++) begin
            apply_stimulus(vecs1[i].en, vecs1[i].clr, vecs1[i].in_bit,
                           vecs1[i].target, vecs1[i].mode);
            check1($sformatf("v1[%0d]", i), vecs1[i].out, vecs1[i].hit,
                   vecs1[i].rl[0], vecs1[i].cnt[1:0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/string_detector_param.md
Name: string_detector_param

Overview:
- Parametrised successor to the team's fixed 3-ones Moore string detector.
- Detects a run of RUN_LEN consecutive samples equal to a selectable target bit, with a sample-enable qualifier.
- Two run modes: overlapping/level and non-overlapping/restart.
- Exposes the live run length and a saturating detection counter; used by the key/sensor front-end as a generic debounce and run detector.

Parameters:
- RUN_LEN, 3, consecutive matching samples required for a detection; legal range >= 1.
- CNT_W, 8, width of hit_cnt.
- RL_W, $clog2(RUN_LEN+1), width of run_len; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample qualifier; in is evaluated only on edges where en=1.
- clr  input  1  synchronous clear of state, run_len and hit_cnt; has priority over en.
- in  input  1  serial data bit.
- target  input  1  bit value being counted (0 or 1); sampled together with in.
- mode  input  1  0 = overlapping/level, 1 = non-overlapping/restart.
- out  output  1  Moore level; high while the current run is >= RUN_LEN.
- hit  output  1  one-clock pulse per detection.
- run_len  output  RL_W  current run length, saturating at RUN_LEN.
- hit_cnt  output  CNT_W  detection count, saturating at all-ones.

Behaviour:
- Reset (rst=0, asynchronous): state=S_IDLE; out, hit, run_len and hit_cnt all 0. Outputs are 0 immediately, with no clock required.
- All outputs are registered. out is decoded from the state register only (Moore). No combinational path from in to any output.
- Match definition: match = (in == target) on an edge where en=1.
- States:
  - S_IDLE: run=0.
  - S_RUN: 0 < run < RUN_LEN.
  - S_HIT: run just reached RUN_LEN.
  - S_HOLD: level mode only, run continuing beyond RUN_LEN.
- Transitions on edges with en=1 and clr=0:
  - Any state, no match: go to S_IDLE, run_len=0.
  - S_IDLE, match: if RUN_LEN==1 go to S_HIT with run_len=1; else go to S_RUN with run_len=1.
  - S_RUN, match: run_len+1. If the new value equals RUN_LEN go to S_HIT, else stay in S_RUN.
  - S_HIT, match, mode=0: go to S_HOLD; run_len stays at RUN_LEN.
  - S_HIT, match, mode=1: restart; behave exactly as S_IDLE+match (run_len=1; S_HIT if RUN_LEN==1).
  - S_HOLD, match: stay in S_HOLD; run_len stays at RUN_LEN.
- out = 1 in S_HIT or S_HOLD; 0 otherwise.
- hit = 1 for exactly the one clock following each edge that enters S_HIT. This includes S_HIT->S_HIT in mode=1 with RUN_LEN==1, which pulses on consecutive cycles. hit=0 on all other edges, including en=0 edges.
- hit_cnt increments on each edge that sets hit; it holds at 2^CNT_W-1 and never wraps.
- Latency: the sample completing the run is taken at edge k; out and hit are high after edge k, i.e. visible during cycle k+1.
- en=0: state, out, run_len and hit_cnt hold; hit is forced to 0. A stalled sample does not break a run.
- clr=1 (sync): state=S_IDLE; out=0, hit=0, run_len=0, hit_cnt=0, regardless of en.
- mode or target changing mid-run: takes effect from the next en=1 edge. No retroactive recount; the existing run_len is kept if the new comparison matches.
- rst asserted mid-run: immediate return to reset values. The first detection after release needs a full RUN_LEN matching samples.

Test Plan:
- RUN_LEN=3, mode=0, target=1, en=1, in=0,1,1,1,1,1,0 -> out rises the cycle after the 3rd 1 and stays high through the 5th 1; hit pulses once; hit_cnt=1; out=0 and run_len=0 after the trailing 0.
- RUN_LEN=3, mode=1, target=1, six consecutive 1s -> hit pulses after the 3rd and 6th 1s; run_len sequence 1,2,3,1,2,3; hit_cnt=2.
- RUN_LEN=3, target=0, in=0,0,en=0 for 4 clocks,0 -> detection after the 3rd qualified 0; run_len holds at 2 during the stall; hit never asserted while en=0.
- RUN_LEN=1, mode=1, CNT_W=2, target=1, six 1s -> hit high on 6 consecutive cycles; hit_cnt reads 1,2,3,3,3,3 (saturates).
- Mid-run events: after 2 matches assert clr with en=1 and in matching -> run_len=0, hit_cnt=0, no hit. Repeat, then pulse rst low asynchronously between edges -> all outputs 0 immediately; 3 further matches are required to detect.
